mem_responder: RTL
==================

// Module: mem_responder
// PURPOSE
//  Word-addressed memory target for the multicycle datapath.
//  Sits on the far side of the address/data registers: it accepts a one-cycle request
//  (address, write enable, write data), waits a programmable number of cycles,
//  then completes the access with a one-cycle ready pulse.
//  Used as the shared instruction/data memory so the control FSM sees a real wait-state interface.
// PARAMETERS
//  DEPTH    64  number of 32-bit words; valid byte addresses 0 .. 4*DEPTH-1
//  AW       6   word-index width, clog2(DEPTH)
//  LATENCY  2   wait cycles between request acceptance and ready; legal range 1..15
// PORTS
//  CLK    in   1   single clock, rising edge
//  RST    in   1   asynchronous, active-low reset
//  req    in   1   request strobe; sampled only in IDLE
//  we     in   1   1 = write, 0 = read; sampled with req
//  addr   in   32  byte address; sampled with req
//  wdata  in   32  write data; sampled with req
//  busy   out  1   high in BUSY and DONE
//  ready  out  1   one-cycle completion pulse (high in DONE)
//  err    out  1   valid with ready: access rejected
//  rdata  out  32  read data; valid while ready && !we_q && !err
// BEHAVIOUR
//  Reset (RST=0, async):
//   - state=IDLE; busy=0, ready=0, err=0, rdata=0; counter=0.
//   - Memory array is NOT cleared.
//   - Reset mid-access aborts the access; a pending write is never committed.
//  FSM: IDLE -> BUSY -> DONE -> IDLE.
//   IDLE: on an edge with req=1, latch addr_q/we_q/wdata_q, cnt=LATENCY-1, go BUSY.
//         req=0 stays IDLE.
//   BUSY: if cnt==0, go DONE; else cnt-=1.
//         Perform the access on this transition edge:
//         - write: mem[addr_q[AW+1:2]] <= wdata_q
//         - read: rdata <= that word
//   DONE: ready=1 for exactly one cycle; next edge goes IDLE.
//  Latency:
//   - req sampled at edge E0 -> ready high in the cycle after edge E0+LATENCY.
//   - Minimum request-to-request spacing is LATENCY+2 edges.
//  Handshake:
//   - req is ignored outside IDLE (no queueing).
//   - addr/we/wdata may change freely after E0.
//  Errors:
//   - Error if addr[1:0]!=0 or addr >= 4*DEPTH.
//   - err=1 with ready; no write, rdata keeps its previous value; timing is unchanged.
//  Width rules:
//   - Only the addr[AW+1:2] word index is used.
//   - Upper address bits count only toward the range check.
//   - Counter is 4 bits.
//  rdata holds its last read value until the next successful read.
//  err and ready are 0 except in DONE.
//  Simultaneous req with reset release: the first edge after RST rises may accept it.
// STRUCTURE
//  Shared package: state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2) and the word/address widths.
//  One sub-module: mem_array (sync write, registered read, DEPTH x 32, no reset).
//  FSM, counter, latch registers and range check live in mem_responder.
// TESTING
//  1 Reset, LATENCY=2: write 0xDEADBEEF @0x10 at E0
//    -> busy at E0, ready=1 after E2, err=0, busy=0 after E3.
//  2 Read @0x10 after test 1
//    -> ready after E0+2 with rdata=0xDEADBEEF; rdata holds after ready falls.
//  3 Write @0x13 (misaligned), then read @0x10
//    -> err=1 with ready; the read returns 0xDEADBEEF (unchanged).
//  4 Read @0x100 with DEPTH=64
//    -> err=1 with ready; rdata unchanged.
//  5 Pulse req every cycle for 10 cycles
//    -> only requests seen in IDLE are accepted; ready spacing is exactly LATENCY+2 cycles.
//  6 Write 0x12345678 @0x20, assert RST during BUSY, release, read @0x20
//    -> all outputs 0 during reset; the read returns the old value, not 0x12345678.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: shared state encoding and bus widths for the memory responder.
package mem_responder_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
endpackage

// File: rtl/mem_array.sv
// mem_array: DEPTH x 32 storage with synchronous write and registered read, no reset.
import mem_responder_pkg::*;

module mem_array #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [AW-1:0]     idx,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we)
            mem[idx] <= wdata;
        if (re)
            rdata_q <= mem[idx];
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/mem_responder.sv
// mem_responder: word-addressed memory target with programmable wait states and a one-cycle ready pulse.
import mem_responder_pkg::*;

module mem_responder #(
    parameter int DEPTH   = 64,
    parameter int AW      = $clog2(DEPTH),
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              ready,
    output logic              err,
    output logic [DATA_W-1:0] rdata
);
    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic              we_q, we_d;
    logic              err_q, err_d;
    logic              vld_q, vld_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] mem_rd;
    logic              fire;
    logic              addr_bad;

    always_comb begin
        addr_bad = (addr[1:0] != 2'b00) || (addr >= ADDR_W'(4 * DEPTH));
        fire     = (state_q == BUSY) && (cnt_q == 4'd0);
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        we_d     = we_q;
        err_d    = err_q;
        wdata_d  = wdata_q;
        // rdata stays masked to zero until the first successful read after reset
        vld_d    = vld_q | (fire & ~we_q & ~err_q);
        case (state_q)
            IDLE: if (req) begin
                state_d = BUSY;
                cnt_d   = 4'(LATENCY - 1);
                idx_d   = addr[AW+1:2];
                we_d    = we;
                err_d   = addr_bad;
                wdata_d = wdata;
            end
            BUSY: begin
                state_d = (cnt_q == 4'd0) ? DONE : BUSY;
                cnt_d   = (cnt_q == 4'd0) ? cnt_q : cnt_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            vld_q   <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            we_q    <= we_d;
            err_q   <= err_d;
            vld_q   <= vld_d;
            wdata_q <= wdata_d;
        end
    end

    mem_array #(.DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk   (clk),
        .we    (fire & we_q & ~err_q),
        .re    (fire & ~we_q & ~err_q),
        .idx   (idx_q),
        .wdata (wdata_q),
        .rdata (mem_rd)
    );

    assign busy  = state_q != IDLE;
    assign ready = state_q == DONE;
    assign err   = ready & err_q;
    assign rdata = vld_q ? mem_rd : '0;
endmodule
